pulse_counter_multi: RTL and testbench
======================================

# pulse_counter_multi

Multi-channel, parametrised edge counter for asynchronous pulse inputs, measured over a gated window. It synchronises each `pulse_in` bit into the `clk` domain and counts the selected edge type while the window is open. At window close it freezes the counts and raises a one-cycle `done`. It extends the single-channel 16-bit pulse counter with:

- per-design channel count and counter width;
- selectable edge mode;
- saturate or wrap overflow handling, with sticky overflow flags.

## Interface
- `CHANNELS`, 4: number of independent pulse inputs/counters (≥1)
- `WIDTH`, 16: counter width per channel (≥2)
- `SYNC_STAGES`, 2: synchroniser flops per input (≥2)
- `SATURATE`, 0: 1 = counters hold at all-ones on overflow; 0 = wrap to 0
- `clk`, input, 1: sole clock
- `rst`, input, 1: reset, asynchronous and active-high
- `pulse_in`, input, `CHANNELS`: asynchronous pulse sources; bit i belongs to channel i
- `en_count`, input, 1: window gate, synchronous to `clk`
- `edge_mode`, input, 2: 00 rising, 01 falling, 10 both, 11 treated as rising; captured at window open
- `count`, output, `CHANNELS*WIDTH`: channel i at `[i*WIDTH +: WIDTH]`
- `overflow`, output, `CHANNELS`: sticky per-channel overflow flag
- `busy`, output, 1: high while the window is open (state COUNT)
- `done`, output, 1: one-cycle pulse after window close

## Operation
- **Synchroniser:** per channel, a `SYNC_STAGES`-deep flop chain followed by one history flop `sd`. Let `s` be the last sync stage.
  - rise = `s & ~sd`
  - fall = `~s & sd`
  - An edge is selected per the latched mode.
- **FSM:** two states, IDLE and COUNT.
  - IDLE with `en_count`=1 → COUNT. On that clock edge: all counters clear to 0, all overflow flags clear, `edge_mode` is latched into `mode_q`. No edge is counted on this clock edge.
  - COUNT with `en_count`=1 → stay in COUNT and count.
  - COUNT with `en_count`=0 → IDLE. The count still applies on this transition edge. `done` is registered high for the following cycle only.
- **Counting:** on every `clk` edge where the pre-edge state is COUNT and channel i has a selected edge, counter i increments by 1.
- **Overflow, counter at all-ones plus another edge:**
  - `SATURATE`=1: counter holds at 2^WIDTH−1 and `overflow[i]` sets.
  - `SATURATE`=0: counter wraps to 0 and `overflow[i]` sets.
  - `overflow[i]` stays set until the next window open or `rst`.
- **Outputs:**
  - `count` is the live counter value.
  - In IDLE, counters are frozen: `count` holds the last window's result until the next window opens.
  - `busy` = (state == COUNT).
- **Edge mode:** changes to `edge_mode` during COUNT have no effect. `mode_q` updates only on the IDLE→COUNT edge.
- **Reset:** `rst` asserted at any time, including mid-window:
  - state → IDLE;
  - all counters 0, `overflow` 0, `done` 0, `busy` 0;
  - sync chains and `sd` to 0, `mode_q` to 00.
  - Consequence: a `pulse_in` held high across reset release appears as one rising edge `SYNC_STAGES` cycles later. It is counted only if a window is open by then.
- **Simultaneous events:** a selected edge and the window-close edge in the same cycle is counted. A selected edge on the window-open edge is discarded, because the clear wins.

## Timing
- Reset values: `count`=0, `overflow`=0, `busy`=0, `done`=0.
- **Input latency:** `pulse_in` first sampled at its new level on `clk` edge k, with the window open throughout → counter increments on edge k+`SYNC_STAGES`.
- **Window open:** `en_count` high at edge n:
  - `busy` high after edge n;
  - first countable clock edge is n+1.
- **Window close:** `en_count` low at edge m:
  - `busy` low after edge m;
  - `done` high from edge m+1 to edge m+2;
  - `count` final and stable from edge m onward.
- **Back-to-back windows:**
  - `en_count` low for exactly one cycle: `done` pulses, then counters clear on the next open edge.
  - The result is readable for at least the one IDLE cycle.
- **Pulse width:** pulses must stay high and low for at least 2 `clk` periods each. Shorter pulses may be missed; this is not an error condition.
- `done` never asserts without a preceding COUNT state. After reset, `done` stays 0 until a complete window has closed.

## Test plan
- **Baseline:** `clk` period 10 ns; `pulse_in[0]` toggling every 20 ns, phase-fixed; `edge_mode`=00; `en_count` high for 1000 cycles → `count[0]`=250, `overflow[0]`=0, `done` high exactly 1 cycle, 1 cycle after `en_count` falls.
- **Edge modes:** same stimulus with `edge_mode`=10 → 500; with `edge_mode`=01 → 250. Changing `edge_mode` mid-window → result unchanged from the value latched at open.
- **Overflow:** `WIDTH`=4, 20 rising edges in one window:
  - `SATURATE`=1 → `count`=15, `overflow`=1;
  - `SATURATE`=0 → `count`=4, `overflow`=1.
  - Next window opens → both clear to 0.
- **Multi-channel:** `CHANNELS`=4, half-periods 20/30/50/100 ns, 1200-cycle window, rising mode → counts 300/200/120/60, with no cross-channel interference.
- **Reset mid-window:** assert `rst` 400 cycles into a window → `count`=0, `busy`=0, `done` never pulses. New window after release → counting restarts from 0.
- **Back-to-back windows:** `en_count` low for 1 cycle between two 100-cycle windows with 40 ns pulse period → `done` pulses after each window; each result is 25; the second window starts from 0.

Source files
------------

// File: rtl/pulse_counter_multi.sv
// -----------------------------------------------------------------------------
// pulse_counter_multi
//
// Multi-channel gated edge counter for asynchronous pulse inputs. Each pulse
// input is synchronised into the clk domain. While the measurement window is
// open, the block counts the selected edge type on every channel. When the
// window closes, the counts freeze and done pulses for one cycle.
//
// Parameters
//   CHANNELS    number of independent pulse inputs / counters (>=1)
//   WIDTH       counter width per channel (>=2)
//   SYNC_STAGES synchroniser flops per input (>=2)
//   SATURATE    1 = hold at all-ones on overflow, 0 = wrap to zero
//
// Ports
//   clk        sole clock
//   rst        asynchronous active-high reset
//   pulse_in   asynchronous pulse sources, bit i feeds channel i
//   en_count   window gate, synchronous to clk
//   edge_mode  00 rising, 01 falling, 10 both, 11 rising; latched at open
//   count      live counters, channel i at [i*WIDTH +: WIDTH]
//   overflow   sticky per-channel overflow flags, cleared at window open
//   busy       high while the window is open
//   done       one-cycle pulse, one cycle after the window closes
// -----------------------------------------------------------------------------
module pulse_counter_multi #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int SATURATE    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       pulse_in,
    input  logic                      en_count,
    input  logic [1:0]                edge_mode,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       overflow,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   win_open;
    logic                   win_close;
    logic                   close_q;
    logic [1:0]             mode_q;

    logic [SYNC_STAGES-1:0] sync [CHANNELS];
    logic [CHANNELS-1:0]    sd;
    logic [CHANNELS-1:0]    s;
    logic [CHANNELS-1:0]    rise;
    logic [CHANNELS-1:0]    fall;
    logic [CHANNELS-1:0]    hit;
    logic [WIDTH-1:0]       cnt [CHANNELS];

    // Synchroniser chains plus one history flop per channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync[i] <= '0;
            end
            sd <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync[i] <= {sync[i][SYNC_STAGES-2:0], pulse_in[i]};
                sd[i]   <= sync[i][SYNC_STAGES-1];
            end
        end
    end

    // Edge detection and selection by the mode latched at window open
    always_comb begin
        s    = '0;
        rise = '0;
        fall = '0;
        hit  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            s[i]    = sync[i][SYNC_STAGES-1];
            rise[i] = s[i] & ~sd[i];
            fall[i] = ~s[i] & sd[i];
            case (mode_q)
                2'b01:   hit[i] = fall[i];
                2'b10:   hit[i] = rise[i] | fall[i];
                default: hit[i] = rise[i];
            endcase
        end
    end

    // Window FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mode_q  <= 2'b00;
            close_q <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            if (win_open) begin
                mode_q <= edge_mode;
            end
            // done lags the close edge by one extra cycle
            close_q <= win_close;
            done    <= close_q;
        end
    end

    // Window FSM: next state
    always_comb begin
        state_next = state;
        win_open   = 1'b0;
        win_close  = 1'b0;
        case (state)
            IDLE: begin
                if (en_count) begin
                    state_next = COUNT;
                    win_open   = 1'b1;
                end
            end
            COUNT: begin
                if (!en_count) begin
                    state_next = IDLE;
                    win_close  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters: the open edge only clears (edges on it are dropped);
    // the close edge still counts because the pre-edge state is COUNT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
            overflow <= '0;
        end else if (win_open) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
            overflow <= '0;
        end else if (state == COUNT) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (hit[i]) begin
                    if (&cnt[i]) begin
                        overflow[i] <= 1'b1;
                        if (SATURATE == 0) begin
                            cnt[i] <= '0;
                        end
                    end else begin
                        cnt[i] <= cnt[i] + WIDTH'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            count[i*WIDTH +: WIDTH] = cnt[i];
        end
    end

    assign busy = (state == COUNT);

endmodule

// File: tb/tb_pulse_counter_multi.sv
// -----------------------------------------------------------------------------
// tb_pulse_counter_multi
//
// Directed bench for pulse_counter_multi. A 4-channel 16-bit instance carries
// the main scenarios; two 1-channel 4-bit instances (saturating and wrapping)
// share channel 0's pulse source for the overflow scenario. Pulse sources are
// phase-fixed square waves with half-periods of 2/3/5/10 clk cycles.
// -----------------------------------------------------------------------------
module tb_pulse_counter_multi;

    logic        clk;
    logic        rst;
    logic [3:0]  pulse;
    logic        en_count;
    logic [1:0]  edge_mode;

    logic [63:0] count;
    logic [3:0]  overflow;
    logic        busy;
    logic        done;

    logic [3:0]  count_sat;
    logic [0:0]  overflow_sat;
    logic        busy_sat;
    logic        done_sat;

    logic [3:0]  count_wrap;
    logic [0:0]  overflow_wrap;
    logic        busy_wrap;
    logic        done_wrap;

    int n_checks;
    int n_pass;
    int cyc;
    logic saw_done;

    pulse_counter_multi #(
        .CHANNELS(4), .WIDTH(16), .SYNC_STAGES(2), .SATURATE(0)
    ) dut (
        .clk(clk), .rst(rst), .pulse_in(pulse), .en_count(en_count),
        .edge_mode(edge_mode), .count(count), .overflow(overflow),
        .busy(busy), .done(done)
    );

    pulse_counter_multi #(
        .CHANNELS(1), .WIDTH(4), .SYNC_STAGES(2), .SATURATE(1)
    ) dut_sat (
        .clk(clk), .rst(rst), .pulse_in(pulse[0:0]), .en_count(en_count),
        .edge_mode(edge_mode), .count(count_sat), .overflow(overflow_sat),
        .busy(busy_sat), .done(done_sat)
    );

    pulse_counter_multi #(
        .CHANNELS(1), .WIDTH(4), .SYNC_STAGES(2), .SATURATE(0)
    ) dut_wrap (
        .clk(clk), .rst(rst), .pulse_in(pulse[0:0]), .en_count(en_count),
        .edge_mode(edge_mode), .count(count_wrap), .overflow(overflow_wrap),
        .busy(busy_wrap), .done(done_wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Phase-fixed square waves: half-periods 2, 3, 5, 10 cycles (20/30/50/100 ns)
    initial begin
        pulse = '0;
        cyc   = 0;
        forever begin
            @(negedge clk);
            cyc++;
            pulse[0] = ((cyc / 2)  % 2) == 1;
            pulse[1] = ((cyc / 3)  % 2) == 1;
            pulse[2] = ((cyc / 5)  % 2) == 1;
            pulse[3] = ((cyc / 10) % 2) == 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ch(input int i);
        return count[i*16 +: 16];
    endfunction

    // Raise en_count before edge n; return just after edge n with busy checked
    task automatic open_win(input string tag);
        en_count = 1'b1;
        @(negedge clk);
        check({tag, " busy after open"}, 32'(busy), 32'd1);
        check({tag, " count0 cleared at open"}, 32'(ch(0)), 32'd0);
    endtask

    // Drop en_count before edge m and check the busy/done timing
    task automatic close_win(input string tag);
        en_count = 1'b0;
        @(negedge clk);
        check({tag, " busy after close"}, 32'(busy), 32'd0);
        check({tag, " done not yet"}, 32'(done), 32'd0);
        @(negedge clk);
        check({tag, " done pulse"}, 32'(done), 32'd1);
        @(negedge clk);
        check({tag, " done one cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        en_count  = 1'b0;
        edge_mode = 2'b00;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset count", count[31:0], 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Baseline rising, 1000-cycle window, period 4 cycles
        edge_mode = 2'b00;
        open_win("rise");
        repeat (999) @(negedge clk);
        close_win("rise");
        check("rise count0", 32'(ch(0)), 32'd250);
        check("rise overflow0", 32'(overflow[0]), 32'd0);

        // Both edges
        edge_mode = 2'b10;
        open_win("both");
        repeat (999) @(negedge clk);
        close_win("both");
        check("both count0", 32'(ch(0)), 32'd500);

        // Falling edges
        edge_mode = 2'b01;
        open_win("fall");
        repeat (999) @(negedge clk);
        close_win("fall");
        check("fall count0", 32'(ch(0)), 32'd250);

        // Mode changed mid-window has no effect
        edge_mode = 2'b00;
        open_win("modechg");
        repeat (300) @(negedge clk);
        edge_mode = 2'b10;
        repeat (699) @(negedge clk);
        close_win("modechg");
        check("modechg count0", 32'(ch(0)), 32'd250);
        edge_mode = 2'b00;

        // Overflow: 20 rising edges into 4-bit counters
        open_win("ovf");
        repeat (79) @(negedge clk);
        close_win("ovf");
        check("ovf main count0", 32'(ch(0)), 32'd20);
        check("ovf main flag0", 32'(overflow[0]), 32'd0);
        check("ovf sat count", 32'(count_sat), 32'd15);
        check("ovf sat flag", 32'(overflow_sat), 32'd1);
        check("ovf wrap count", 32'(count_wrap), 32'd4);
        check("ovf wrap flag", 32'(overflow_wrap), 32'd1);
        // Held in IDLE, results stay frozen
        repeat (10) @(negedge clk);
        check("frozen wrap count", 32'(count_wrap), 32'd4);
        check("frozen wrap flag", 32'(overflow_wrap), 32'd1);
        // Next open clears both
        open_win("reopen");
        check("reopen sat count", 32'(count_sat), 32'd0);
        check("reopen sat flag", 32'(overflow_sat), 32'd0);
        check("reopen wrap count", 32'(count_wrap), 32'd0);
        check("reopen wrap flag", 32'(overflow_wrap), 32'd0);
        repeat (39) @(negedge clk);
        close_win("reopen");
        check("reopen main count0", 32'(ch(0)), 32'd10);
        check("reopen sat count10", 32'(count_sat), 32'd10);

        // Multi-channel, 1200-cycle window
        open_win("multi");
        repeat (1199) @(negedge clk);
        close_win("multi");
        check("multi count0", 32'(ch(0)), 32'd300);
        check("multi count1", 32'(ch(1)), 32'd200);
        check("multi count2", 32'(ch(2)), 32'd120);
        check("multi count3", 32'(ch(3)), 32'd60);
        check("multi overflow", 32'(overflow), 32'd0);

        // Reset mid-window
        open_win("rstmid");
        repeat (400) @(negedge clk);
        check("rstmid count before reset", 32'(ch(0)), 32'd100);
        rst      = 1'b1;
        en_count = 1'b0;
        #1;
        check("rstmid async count", count[31:0], 32'd0);
        check("rstmid async busy", 32'(busy), 32'd0);
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        check("rstmid done never", 32'(saw_done), 32'd0);
        check("rstmid busy idle", 32'(busy), 32'd0);
        open_win("rstnew");
        repeat (99) @(negedge clk);
        close_win("rstnew");
        check("rstnew count0", 32'(ch(0)), 32'd25);

        // Back-to-back windows, one IDLE cycle between
        open_win("b2b1");
        repeat (99) @(negedge clk);
        en_count = 1'b0;
        @(negedge clk);
        check("b2b1 busy", 32'(busy), 32'd0);
        check("b2b1 count0", 32'(ch(0)), 32'd25);
        en_count = 1'b1;
        @(negedge clk);
        check("b2b1 done", 32'(done), 32'd1);
        check("b2b2 busy", 32'(busy), 32'd1);
        check("b2b2 cleared", 32'(ch(0)), 32'd0);
        repeat (99) @(negedge clk);
        close_win("b2b2");
        check("b2b2 count0", 32'(ch(0)), 32'd25);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
